// File: rtl/minitb_ahb_pkg.sv
// Shared types for the minitb AHB-lite responder: htrans/hresp encodings and slave FSM states.
// No logic; pure declarations.
// The ERR1/ERR2 states exist only when MINITB_AHB_SLAVE_ERR_EN is defined.
package minitb_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

`ifdef MINITB_AHB_SLAVE_ERR_EN
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} slave_state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} slave_state_e;
`endif

endpackage

// File: rtl/minitb_ahb_slave_if.sv
// AHB-lite bus bundle between the minitb master and the responder.
// No latency; wires only.
// Flow control is hready: the master holds its address phase while hready is low.
interface minitb_ahb_slave_if #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
) ();
  logic [1:0]           htrans;
  logic [addrWidth-1:0] haddr;
  logic                 hwrite;
  logic [dataWidth-1:0] hwdata;
  logic                 hready;
  logic [dataWidth-1:0] hrdata;
  logic                 hresp;

  modport master (output htrans, haddr, hwrite, hwdata, input hready, hrdata, hresp);
  modport slave  (input htrans, haddr, hwrite, hwdata, output hready, hrdata, hresp);
endinterface

// File: rtl/minitb_ahb_slave_mem.sv
// Word array, one write port and one combinational read port with same-address bypass.
// Write lands at the clock edge; read is combinational.
// No backpressure; the caller gates wr_en.
module minitb_ahb_slave_mem #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
) (
  input  logic                 hclk,
  input  logic                 wr_en,
  input  logic [addrWidth-1:0] wr_addr,
  input  logic [dataWidth-1:0] wr_data,
  input  logic [addrWidth-1:0] rd_addr,
  output logic [dataWidth-1:0] rd_data
);
  logic [dataWidth-1:0] mem_q [1 << addrWidth];

  // Commit the write word; contents survive reset on purpose.
  always_ff @(posedge hclk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // A read of the word being written this edge sees the new data, not the stale word.
  always_comb begin
    rd_data = mem_q[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) rd_data = wr_data;
  end
endmodule

// File: rtl/minitb_ahb_slave.sv
// AHB-lite responder backed by a word memory; optional error window via MINITB_AHB_SLAVE_ERR_EN.
// Data phase lasts WAIT_STATES+1 cycles; back-to-back transfers pipeline without bubbles.
// Stalls the master by holding hready low during wait states and the first error cycle.
module minitb_ahb_slave
  import minitb_ahb_pkg::*;
#(
  parameter int addrWidth   = 8,
  parameter int dataWidth   = 32,
  parameter int WAIT_STATES = 0,
  parameter logic [addrWidth-1:0] ERR_BASE = '1
) (
  input logic hclk,
  input logic hreset,
  minitb_ahb_slave_if.slave bus
);
  slave_state_e         state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic                 hready_q, hready_d;
  logic                 hresp_q, hresp_d;
  logic [dataWidth-1:0] hrdata_q, hrdata_d;
  logic                 accept;
  logic                 mem_we;
  logic [addrWidth-1:0] rd_addr;
  logic [dataWidth-1:0] rd_data;

  assign accept  = hready_q && ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));
  // A write commits on the edge that closes its data phase; reset abandons it.
  assign mem_we  = (state_q == ST_DATA) && write_q && !hreset;
  // During wait states the stored address is read; otherwise the incoming one.
  assign rd_addr = (state_q == ST_WAIT) ? addr_q : bus.haddr;

  minitb_ahb_slave_mem #(.addrWidth(addrWidth), .dataWidth(dataWidth)) u_mem (
    .hclk    (hclk),
    .wr_en   (mem_we),
    .wr_addr (addr_q),
    .wr_data (bus.hwdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State and bus-output registers.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hrdata_q <= '0;
      hresp_q  <= HRESP_OKAY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      hready_q <= hready_d;
      hrdata_q <= hrdata_d;
      hresp_q  <= hresp_d;
    end
  end

  // Next-state: accept in IDLE/DATA/ERR2, count down wait states, walk the error response.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    hready_d = hready_q;
    hrdata_d = hrdata_q;
    hresp_d  = hresp_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = ST_DATA;
          hready_d = 1'b1;
          if (!write_q) hrdata_d = rd_data;
        end
      end
`ifdef MINITB_AHB_SLAVE_ERR_EN
      ST_ERR1: begin
        state_d  = ST_ERR2;
        hready_d = 1'b1;
        hresp_d  = HRESP_ERROR;
      end
`endif
      default: begin
        hresp_d = HRESP_OKAY;
        if (accept) begin
          addr_d  = bus.haddr;
          write_d = bus.hwrite;
          if (WAIT_STATES == 0) begin
            state_d  = ST_DATA;
            hready_d = 1'b1;
            if (!bus.hwrite) hrdata_d = rd_data;
          end else begin
            state_d  = ST_WAIT;
            hready_d = 1'b0;
            cnt_d    = 4'(WAIT_STATES);
          end
`ifdef MINITB_AHB_SLAVE_ERR_EN
          if (bus.haddr >= ERR_BASE) begin
            state_d  = ST_ERR1;
            hready_d = 1'b0;
            hresp_d  = HRESP_ERROR;
            hrdata_d = '0;
            cnt_d    = cnt_q;
          end
`endif
        end else begin
          state_d  = ST_IDLE;
          hready_d = 1'b1;
        end
      end
    endcase
  end

`ifndef MINITB_AHB_SLAVE_ERR_EN
  // The error window is compiled out; ERR_BASE has no effect in this build.
  logic unused_err_base;
  assign unused_err_base = ^ERR_BASE;
`endif

  assign bus.hready = hready_q;
  assign bus.hrdata = hrdata_q;
  assign bus.hresp  = hresp_q;
endmodule

// File: tb/tb_minitb_ahb_slave.sv
// Testbench for minitb_ahb_slave: one zero-wait instance and one three-wait instance.
// Reads are checked against a word-array model updated in transfer order.
module tb_minitb_ahb_slave;
  import minitb_ahb_pkg::*;

  logic hclk = 1'b0;
  logic hreset0, hreset3;
  int   errs = 0;
  int   checks = 0;

  always #5 hclk = ~hclk;

  minitb_ahb_slave_if #(.addrWidth(8), .dataWidth(32)) b0 ();
  minitb_ahb_slave_if #(.addrWidth(8), .dataWidth(32)) b3 ();

  minitb_ahb_slave #(.addrWidth(8), .dataWidth(32), .WAIT_STATES(0), .ERR_BASE(8'hF0)) dut0 (
    .hclk(hclk), .hreset(hreset0), .bus(b0));
  minitb_ahb_slave #(.addrWidth(8), .dataWidth(32), .WAIT_STATES(3), .ERR_BASE(8'hF0)) dut3 (
    .hclk(hclk), .hreset(hreset3), .bus(b3));

  // Transfer list for the zero-wait instance and the reference memory.
  bit          op_wr   [64];
  logic [7:0]  op_addr [64];
  logic [31:0] op_dat  [64];
  int          op_gap  [64];
  logic [31:0] model_mem [256];
  bit          model_vld [256];

  task automatic set_op(input int i, input bit wr, input logic [7:0] a, input logic [31:0] d, input int gap);
    op_wr[i] = wr; op_addr[i] = a; op_dat[i] = d; op_gap[i] = gap;
  endtask

  // Pipelined master on b0; entered and left at a negedge with the bus idle and hready high.
  task automatic run_ops(input string tag, input int n);
    int pend = -1;
    int nxt = 0;
    int cycles = 0;
    int gap_left = op_gap[0];
    int exp_cycles = n + 1;
    for (int i = 0; i < n; i++) exp_cycles += op_gap[i];
    while ((nxt < n || pend >= 0) && cycles < 1000) begin
      cycles++;
      b0.hwdata = (pend >= 0 && op_wr[pend]) ? op_dat[pend] : $urandom;
      if (b0.hready === 1'b1) begin
        if (pend >= 0) begin
          if (op_wr[pend]) begin
            model_mem[op_addr[pend]] = op_dat[pend];
            model_vld[op_addr[pend]] = 1'b1;
          end else if (model_vld[op_addr[pend]]) begin
            checks++;
            if (b0.hrdata !== model_mem[op_addr[pend]]) begin
              errs++;
              $display("FAIL %s read[%0d] addr=%h got=%h want=%h", tag, pend, op_addr[pend],
                       b0.hrdata, model_mem[op_addr[pend]]);
            end
          end
        end
        pend = -1;
        if (nxt < n && gap_left == 0) begin
          b0.htrans = $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
          b0.haddr  = op_addr[nxt];
          b0.hwrite = op_wr[nxt];
          pend = nxt;
          nxt++;
          if (nxt < n) gap_left = op_gap[nxt];
        end else begin
          if (gap_left > 0) gap_left--;
          b0.htrans = $urandom_range(0, 1) ? HTRANS_IDLE : HTRANS_BUSY;
          b0.haddr  = 8'($urandom);
          b0.hwrite = 1'($urandom);
        end
      end else begin
        b0.htrans = HTRANS_IDLE;
      end
      @(negedge hclk);
    end
    b0.htrans = HTRANS_IDLE;
    checks++;
    if (cycles !== exp_cycles) begin
      errs++;
      $display("FAIL %s cycles got=%0d want=%0d", tag, cycles, exp_cycles);
    end
  endtask

  // One transfer on b3; returns at the negedge where hready is high in its data phase.
  task automatic ws3_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                          output int lows, output logic [31:0] rd);
    b3.htrans = HTRANS_NONSEQ; b3.haddr = a; b3.hwrite = wr;
    lows = 0;
    @(negedge hclk);
    b3.htrans = HTRANS_IDLE;
    b3.hwdata = wr ? d : $urandom;
    while (b3.hready !== 1'b1 && lows < 20) begin
      lows++;
      @(negedge hclk);
    end
    rd = b3.hrdata;
  endtask

  task automatic test_reset();
    hreset0 = 1'b1; hreset3 = 1'b1;
    b0.htrans = HTRANS_IDLE; b0.haddr = '0; b0.hwrite = 1'b0; b0.hwdata = '0;
    b3.htrans = HTRANS_IDLE; b3.haddr = '0; b3.hwrite = 1'b0; b3.hwdata = '0;
    repeat (3) @(negedge hclk);
    hreset0 = 1'b0; hreset3 = 1'b0;
    repeat (2) @(negedge hclk);
    checks += 6;
    if (b0.hready !== 1'b1) begin errs++; $display("FAIL reset hready0 got=%b want=1", b0.hready); end
    if (b0.hresp  !== 1'b0) begin errs++; $display("FAIL reset hresp0 got=%b want=0", b0.hresp); end
    if (b0.hrdata !== 32'h0) begin errs++; $display("FAIL reset hrdata0 got=%h want=0", b0.hrdata); end
    if (b3.hready !== 1'b1) begin errs++; $display("FAIL reset hready3 got=%b want=1", b3.hready); end
    if (b3.hresp  !== 1'b0) begin errs++; $display("FAIL reset hresp3 got=%b want=0", b3.hresp); end
    if (b3.hrdata !== 32'h0) begin errs++; $display("FAIL reset hrdata3 got=%h want=0", b3.hrdata); end
  endtask

  task automatic test_forward();
    set_op(0, 1'b1, 8'h10, 32'hDEADBEEF, 0);
    set_op(1, 1'b0, 8'h10, 32'h0, 0);
    run_ops("forward", 2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) set_op(i, 1'b1, 8'(i + 1), 32'(i + 1), 0);
    for (int i = 0; i < 3; i++) set_op(3 + i, 1'b0, 8'(3 - i), 32'h0, 0);
    run_ops("b2b", 6);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) set_op(i, 1'b1, 8'(8'h30 + i), $urandom, 0);
    run_ops("preload", 16);
    for (int i = 0; i < 48; i++)
      set_op(i, 1'($urandom_range(0, 1)), 8'(8'h30 + $urandom_range(0, 15)), $urandom, $urandom_range(0, 2));
    run_ops("random", 48);
  endtask

  task automatic test_wait_states();
    int lows;
    logic [31:0] rd;
    logic [31:0] v = $urandom;
    ws3_xfer(1'b1, 8'h22, v, lows, rd);
    checks++;
    if (lows !== 3) begin errs++; $display("FAIL ws3 write lows got=%0d want=3", lows); end
    ws3_xfer(1'b0, 8'h22, 32'h0, lows, rd);
    checks += 2;
    if (lows !== 3) begin errs++; $display("FAIL ws3 read lows got=%0d want=3", lows); end
    if (rd !== v) begin errs++; $display("FAIL ws3 read data got=%h want=%h", rd, v); end
    @(negedge hclk);
  endtask

  task automatic test_reset_mid();
    int lows;
    logic [31:0] rd;
    ws3_xfer(1'b1, 8'h05, 32'h11, lows, rd);
    @(negedge hclk);
    b3.htrans = HTRANS_NONSEQ; b3.haddr = 8'h05; b3.hwrite = 1'b1;
    @(negedge hclk);
    b3.htrans = HTRANS_IDLE; b3.hwdata = 32'h55;
    checks++;
    if (b3.hready !== 1'b0) begin errs++; $display("FAIL rstmid wait hready got=%b want=0", b3.hready); end
    @(negedge hclk);
    hreset3 = 1'b1;
    @(negedge hclk);
    hreset3 = 1'b0;
    checks += 2;
    if (b3.hready !== 1'b1) begin errs++; $display("FAIL rstmid hready got=%b want=1", b3.hready); end
    if (b3.hresp !== 1'b0) begin errs++; $display("FAIL rstmid hresp got=%b want=0", b3.hresp); end
    ws3_xfer(1'b0, 8'h05, 32'h0, lows, rd);
    checks++;
    if (rd !== 32'h11) begin errs++; $display("FAIL rstmid readback got=%h want=00000011", rd); end
    @(negedge hclk);
  endtask

`ifdef MINITB_AHB_SLAVE_ERR_EN
  task automatic test_error();
    b0.htrans = HTRANS_NONSEQ; b0.haddr = 8'hF4; b0.hwrite = 1'b1;
    @(negedge hclk);
    b0.htrans = HTRANS_IDLE; b0.hwdata = 32'd7;
    checks += 2;
    if (b0.hready !== 1'b0) begin errs++; $display("FAIL err1 hready got=%b want=0", b0.hready); end
    if (b0.hresp !== 1'b1) begin errs++; $display("FAIL err1 hresp got=%b want=1", b0.hresp); end
    @(negedge hclk);
    checks += 3;
    if (b0.hready !== 1'b1) begin errs++; $display("FAIL err2 hready got=%b want=1", b0.hready); end
    if (b0.hresp !== 1'b1) begin errs++; $display("FAIL err2 hresp got=%b want=1", b0.hresp); end
    if (b0.hrdata !== 32'h0) begin errs++; $display("FAIL err2 hrdata got=%h want=0", b0.hrdata); end
    @(negedge hclk);
    checks += 2;
    if (b0.hresp !== 1'b0) begin errs++; $display("FAIL errdone hresp got=%b want=0", b0.hresp); end
    if (dut0.u_mem.mem_q[8'hF4] === 32'd7) begin
      errs++; $display("FAIL err nowrite mem got=%h want=unwritten", dut0.u_mem.mem_q[8'hF4]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_back_to_back();
    test_wait_states();
    test_reset_mid();
    test_random();
`ifdef MINITB_AHB_SLAVE_ERR_EN
    test_error();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
